// File: rtl/bus_alu_core.sv
// ---------------------------------------------------------------------------
// bus_alu_core
//
// Processor-side core of the Mini-SRC datapath. It contains:
//   * a priority encoder that turns the bus "out" strobes into a 5-bit select
//     (the lowest asserted strobe wins; no strobe selects code 31),
//   * the 32-bit bus multiplexer,
//   * the combinational ALU (A = Y register, B = bus),
//   * the Y, Zhigh and Zlow registers around the ALU.
//
// Ports:
//   clock            rising-edge system clock
//   clear            asynchronous active-low reset of Y/Zhigh/Zlow
//   r_q              R0..R15 contents, Rn at [32n+31:32n]
//   hi_q, lo_q, pc_q, mdr_q, inport_q, c_sign_extended
//                    other 32-bit bus sources held outside this block
//   r_out            Rn bus drive strobes (bit n = Rn)
//   HIout .. Cout    remaining bus drive strobes
//   Yin, Zhighin, Zlowin  independent register load enables
//   IncPC            forces the ALU to produce B + 1
//   opcode           5-bit ALU operation
//   BusMuxOut        current bus value
//   y_q, zhigh_q, zlow_q  register contents
// ---------------------------------------------------------------------------
module bus_alu_core (
  input  logic         clock,
  input  logic         clear,
  input  logic [511:0] r_q,
  input  logic [31:0]  hi_q,
  input  logic [31:0]  lo_q,
  input  logic [31:0]  pc_q,
  input  logic [31:0]  mdr_q,
  input  logic [31:0]  inport_q,
  input  logic [31:0]  c_sign_extended,
  input  logic [15:0]  r_out,
  input  logic         HIout,
  input  logic         LOout,
  input  logic         Zhighout,
  input  logic         Zlowout,
  input  logic         PCout,
  input  logic         MDRout,
  input  logic         InPortout,
  input  logic         Cout,
  input  logic         Yin,
  input  logic         Zhighin,
  input  logic         Zlowin,
  input  logic         IncPC,
  input  logic [4:0]   opcode,
  output logic [31:0]  BusMuxOut,
  output logic [31:0]  y_q,
  output logic [31:0]  zhigh_q,
  output logic [31:0]  zlow_q
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // -------------------------------------------------------------------------
  // Priority encoder
  // -------------------------------------------------------------------------
  logic [31:0] enc_in;
  logic [4:0]  bus_sel;

  assign enc_in = {8'h00, Cout, InPortout, MDRout, PCout,
                   Zlowout, Zhighout, LOout, HIout, r_out};

  // Scan from the top down so the lowest asserted index is the last to write.
  always_comb begin
    bus_sel = 5'd31;
    for (int i = 23; i >= 0; i--) begin
      if (enc_in[i]) bus_sel = 5'(i);
    end
  end

  // -------------------------------------------------------------------------
  // Bus multiplexer
  // -------------------------------------------------------------------------
  logic [31:0] bus_src [32];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg_src
      assign bus_src[gi] = r_q[32*gi +: 32];
    end
    for (gi = 24; gi < 32; gi++) begin : g_zero_src
      assign bus_src[gi] = 32'h0;
    end
  endgenerate

  assign bus_src[16] = hi_q;
  assign bus_src[17] = lo_q;
  assign bus_src[18] = zhigh_q;
  assign bus_src[19] = zlow_q;
  assign bus_src[20] = pc_q;
  assign bus_src[21] = mdr_q;
  assign bus_src[22] = inport_q;
  assign bus_src[23] = c_sign_extended;

  assign BusMuxOut = bus_src[bus_sel];

  // -------------------------------------------------------------------------
  // ALU
  // -------------------------------------------------------------------------
  logic [31:0]        alu_a;
  logic [31:0]        alu_b;
  logic [4:0]         shamt;
  logic [63:0]        rot_right;
  logic [63:0]        rot_left;
  logic [31:0]        shra_res;
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] product;
  logic               div_by_zero;
  logic               div_overflow;
  logic signed [31:0] div_a;
  logic signed [31:0] div_b;
  logic signed [31:0] quotient;
  logic signed [31:0] remainder;
  logic [31:0]        c_hi;
  logic [31:0]        c_lo;

  assign alu_a = y_q;
  assign alu_b = BusMuxOut;
  assign shamt = alu_b[4:0];

  // Rotates via a doubled word: the wanted 32 bits fall out of one shift.
  assign rot_right = {alu_a, alu_a} >> shamt;
  assign rot_left  = {alu_a, alu_a} << shamt;
  assign shra_res  = $signed(alu_a) >>> shamt;

  assign a_ext   = {{32{alu_a[31]}}, alu_a};
  assign b_ext   = {{32{alu_b[31]}}, alu_b};
  assign product = a_ext * b_ext;

  // The two special division cases get fixed results below; the divider
  // itself is fed a harmless divisor then so it never sees /0 or overflow.
  assign div_by_zero  = (alu_b == 32'h0);
  assign div_overflow = (alu_a == 32'h8000_0000) && (alu_b == 32'hFFFF_FFFF);
  assign div_a        = $signed(alu_a);
  assign div_b        = (div_by_zero || div_overflow) ? 32'sd1 : $signed(alu_b);
  assign quotient     = div_a / div_b;
  assign remainder    = div_a % div_b;

  always_comb begin
    c_hi = 32'h0;
    c_lo = 32'h0;
    if (IncPC) begin
      c_lo = alu_b + 32'd1;
    end else begin
      case (opcode)
        OP_ADD, OP_ADDI: c_lo = alu_a + alu_b;
        OP_SUB:          c_lo = alu_a - alu_b;
        OP_AND, OP_ANDI: c_lo = alu_a & alu_b;
        OP_OR,  OP_ORI:  c_lo = alu_a | alu_b;
        OP_SHR:          c_lo = alu_a >> shamt;
        OP_SHRA:         c_lo = shra_res;
        OP_SHL:          c_lo = alu_a << shamt;
        OP_ROR:          c_lo = rot_right[31:0];
        OP_ROL:          c_lo = rot_left[63:32];
        OP_MUL: begin
          c_hi = product[63:32];
          c_lo = product[31:0];
        end
        OP_DIV: begin
          if (div_by_zero) begin
            c_lo = 32'hFFFF_FFFF;
            c_hi = alu_a;
          end else if (div_overflow) begin
            c_lo = 32'h8000_0000;
            c_hi = 32'h0;
          end else begin
            c_lo = quotient;
            c_hi = remainder;
          end
        end
        OP_NEG:          c_lo = 32'h0 - alu_b;
        OP_NOT:          c_lo = ~alu_b;
        default: begin
          c_hi = 32'h0;
          c_lo = 32'h0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Y / Zhigh / Zlow registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      y_q     <= 32'h0;
      zhigh_q <= 32'h0;
      zlow_q  <= 32'h0;
    end else begin
      if (Yin)     y_q     <= BusMuxOut;
      if (Zhighin) zhigh_q <= c_hi;
      if (Zlowin)  zlow_q  <= c_lo;
    end
  end

endmodule

// File: tb/tb_bus_alu_core.sv
// ---------------------------------------------------------------------------
// tb_bus_alu_core
//
// Self-checking bench for bus_alu_core: directed scenarios from the datapath
// behaviour plus randomized traffic checked against a behavioural model of
// the bus and ALU kept in this file.
// ---------------------------------------------------------------------------
module tb_bus_alu_core;

  logic         clock;
  logic         clear;
  logic [511:0] r_q;
  logic [31:0]  hi_q, lo_q, pc_q, mdr_q, inport_q, c_sign_extended;
  logic [15:0]  r_out;
  logic         HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout;
  logic         Yin, Zhighin, Zlowin, IncPC;
  logic [4:0]   opcode;
  logic [31:0]  BusMuxOut, y_q, zhigh_q, zlow_q;

  int n_pass  = 0;
  int n_total = 0;

  // Model state for the three registers.
  logic [31:0] y_m, zh_m, zl_m;

  bus_alu_core dut (
    .clock(clock), .clear(clear), .r_q(r_q),
    .hi_q(hi_q), .lo_q(lo_q), .pc_q(pc_q), .mdr_q(mdr_q),
    .inport_q(inport_q), .c_sign_extended(c_sign_extended),
    .r_out(r_out), .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .PCout(PCout), .MDRout(MDRout),
    .InPortout(InPortout), .Cout(Cout),
    .Yin(Yin), .Zhighin(Zhighin), .Zlowin(Zlowin), .IncPC(IncPC),
    .opcode(opcode), .BusMuxOut(BusMuxOut),
    .y_q(y_q), .zhigh_q(zhigh_q), .zlow_q(zlow_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ------------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------------
  function automatic logic [31:0] source_val(int idx);
    case (idx)
      16: return hi_q;
      17: return lo_q;
      18: return zh_m;
      19: return zl_m;
      20: return pc_q;
      21: return mdr_q;
      22: return inport_q;
      23: return c_sign_extended;
      default: return (idx < 16) ? r_q[32*idx +: 32] : 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_bus(logic [23:0] strobes);
    for (int i = 0; i < 24; i++)
      if (strobes[i]) return source_val(i);
    return 32'h0;
  endfunction

  task automatic ref_alu(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic inc,
                         output logic [31:0] hi, output logic [31:0] lo);
    int     sa, sb, n;
    longint la, lb, p, q, r;
    logic   t;
    hi = 0; lo = 0;
    sa = a; sb = b; la = sa; lb = sb; n = int'(b[4:0]);
    if (inc) begin
      lo = b + 1;
      return;
    end
    case (op)
      5'd3, 5'd12: lo = a + b;
      5'd4:        lo = a - b;
      5'd5, 5'd13: lo = a & b;
      5'd6, 5'd14: lo = a | b;
      5'd7:        lo = a >> n;
      5'd8: begin
        lo = a;
        repeat (n) lo = {lo[31], lo[31:1]};
      end
      5'd9:        lo = a << n;
      5'd10: begin
        lo = a;
        repeat (n) begin t = lo[0]; lo = {t, lo[31:1]}; end
      end
      5'd11: begin
        lo = a;
        repeat (n) begin t = lo[31]; lo = {lo[30:0], t}; end
      end
      5'd15: begin
        p = la * lb;
        hi = p[63:32]; lo = p[31:0];
      end
      5'd16: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF; hi = a;
        end else begin
          q = la / lb; r = la % lb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
      5'd17: lo = -b;
      5'd18: lo = ~b;
      default: begin hi = 0; lo = 0; end
    endcase
  endtask

  // ------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ------------------------------------------------------------------------
  task automatic idle();
    r_out = 0; HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0;
    PCout = 0; MDRout = 0; InPortout = 0; Cout = 0;
    Yin = 0; Zhighin = 0; Zlowin = 0; IncPC = 0; opcode = 0;
  endtask

  task automatic set_r(int n, logic [31:0] v);
    r_q[32*n +: 32] = v;
  endtask

  task automatic load_y(logic [31:0] v);
    @(negedge clock);
    idle(); set_r(1, v); r_out[1] = 1'b1; Yin = 1'b1;
    @(posedge clock); #1;
    y_m = v;
    idle();
  endtask

  task automatic run_op(logic [4:0] op, logic [31:0] b);
    logic [31:0] h, l;
    @(negedge clock);
    idle(); set_r(2, b); r_out[2] = 1'b1; opcode = op;
    Zhighin = 1'b1; Zlowin = 1'b1;
    ref_alu(op, y_m, b, 1'b0, h, l);
    @(posedge clock); #1;
    zh_m = h; zl_m = l;
    idle();
    $display("op=%b A=%h B=%h -> zhigh=%h zlow=%h", op, y_m, b, zhigh_q, zlow_q);
  endtask

  // ------------------------------------------------------------------------
  // Tests
  // ------------------------------------------------------------------------
  task automatic test_reset();
    clear = 1'b0;
    idle(); Yin = 1'b1; Zhighin = 1'b1; Zlowin = 1'b1; opcode = 5'd18;
    @(posedge clock); #1;
    if (y_q !== 32'h0) $display("FAIL reset_y: got %h want 0", y_q); else n_pass++;
    n_total++;
    if (zhigh_q !== 32'h0) $display("FAIL reset_zhigh: got %h want 0", zhigh_q); else n_pass++;
    n_total++;
    if (zlow_q !== 32'h0) $display("FAIL reset_zlow: got %h want 0", zlow_q); else n_pass++;
    n_total++;
    if (BusMuxOut !== 32'h0) $display("FAIL reset_bus: got %h want 0", BusMuxOut); else n_pass++;
    n_total++;
    @(negedge clock);
    clear = 1'b1; idle();
    y_m = 0; zh_m = 0; zl_m = 0;
    $display("reset: y=%h zhigh=%h zlow=%h bus=%h", y_q, zhigh_q, zlow_q, BusMuxOut);
  endtask

  task automatic test_mux();
    @(negedge clock);
    idle(); set_r(5, 32'h1234_5678); pc_q = 32'hDEAD_0000;
    c_sign_extended = 32'hFFFF_FF80;
    r_out[5] = 1'b1; #1;
    if (BusMuxOut !== 32'h1234_5678) $display("FAIL mux_r5: got %h want 12345678", BusMuxOut); else n_pass++;
    n_total++;
    PCout = 1'b1; #1;
    if (BusMuxOut !== 32'h1234_5678) $display("FAIL mux_priority: got %h want 12345678", BusMuxOut); else n_pass++;
    n_total++;
    idle(); Cout = 1'b1; #1;
    if (BusMuxOut !== 32'hFFFF_FF80) $display("FAIL mux_cout: got %h want ffffff80", BusMuxOut); else n_pass++;
    n_total++;
    $display("mux: cout bus=%h", BusMuxOut);
    idle();
  endtask

  task automatic test_add_sub();
    load_y(32'd5);
    if (y_q !== 32'd5) $display("FAIL load_y: got %h want 5", y_q); else n_pass++;
    n_total++;
    run_op(5'b00011, 32'd3);
    if (zlow_q !== 32'd8) $display("FAIL add_lo: got %h want 8", zlow_q); else n_pass++;
    n_total++;
    if (zhigh_q !== 32'd0) $display("FAIL add_hi: got %h want 0", zhigh_q); else n_pass++;
    n_total++;
    run_op(5'b00100, 32'd3);
    if (zlow_q !== 32'd2) $display("FAIL sub_lo: got %h want 2", zlow_q); else n_pass++;
    n_total++;
    @(negedge clock);
    idle(); pc_q = 32'h10; PCout = 1'b1; IncPC = 1'b1; opcode = 5'b00100; Zlowin = 1'b1;
    @(posedge clock); #1;
    zl_m = 32'h11;
    idle();
    if (zlow_q !== 32'h11) $display("FAIL incpc: got %h want 11", zlow_q); else n_pass++;
    n_total++;
    $display("incpc: zlow=%h", zlow_q);
  endtask

  task automatic test_mul_div();
    load_y(32'hFFFF_FFFD);
    run_op(5'b01111, 32'd7);
    if (zhigh_q !== 32'hFFFF_FFFF) $display("FAIL mul_hi: got %h want ffffffff", zhigh_q); else n_pass++;
    n_total++;
    if (zlow_q !== 32'hFFFF_FFEB) $display("FAIL mul_lo: got %h want ffffffeb", zlow_q); else n_pass++;
    n_total++;
    load_y(32'hFFFF_FFEF);
    run_op(5'b10000, 32'd5);
    if (zlow_q !== 32'hFFFF_FFFD) $display("FAIL div_q: got %h want fffffffd", zlow_q); else n_pass++;
    n_total++;
    if (zhigh_q !== 32'hFFFF_FFFE) $display("FAIL div_r: got %h want fffffffe", zhigh_q); else n_pass++;
    n_total++;
    run_op(5'b10000, 32'd0);
    if (zlow_q !== 32'hFFFF_FFFF) $display("FAIL div0_q: got %h want ffffffff", zlow_q); else n_pass++;
    n_total++;
    if (zhigh_q !== 32'hFFFF_FFEF) $display("FAIL div0_r: got %h want ffffffef", zhigh_q); else n_pass++;
    n_total++;
    load_y(32'h8000_0000);
    run_op(5'b10000, 32'hFFFF_FFFF);
    if (zlow_q !== 32'h8000_0000) $display("FAIL divovf_q: got %h want 80000000", zlow_q); else n_pass++;
    n_total++;
    if (zhigh_q !== 32'h0) $display("FAIL divovf_r: got %h want 0", zhigh_q); else n_pass++;
    n_total++;
  endtask

  task automatic test_shifts();
    logic [4:0]  ops  [4] = '{5'b00111, 5'b01000, 5'b01010, 5'b01011};
    logic [31:0] want [4] = '{32'h4000_0000, 32'hC000_0000, 32'hC000_0000, 32'h0000_0003};
    load_y(32'h8000_0001);
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'd1);
      if (zlow_q !== want[i]) $display("FAIL shift_%b: got %h want %h", ops[i], zlow_q, want[i]); else n_pass++;
      n_total++;
    end
    run_op(5'b10010, 32'd0);
    if (zlow_q !== 32'hFFFF_FFFF) $display("FAIL not0: got %h want ffffffff", zlow_q); else n_pass++;
    n_total++;
    run_op(5'b10001, 32'd1);
    if (zlow_q !== 32'hFFFF_FFFF) $display("FAIL neg1: got %h want ffffffff", zlow_q); else n_pass++;
    n_total++;
  endtask

  // Zlow drives the bus while Zlowin loads: the ALU must see the old Zlow.
  task automatic test_read_during_load();
    logic [31:0] old;
    old = zl_m;
    @(negedge clock);
    idle(); Zlowout = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; Yin = 1'b1;
    @(posedge clock); #1;
    idle();
    zl_m = old + 1; y_m = old;
    if (zlow_q !== old + 32'd1) $display("FAIL rdl_zlow: got %h want %h", zlow_q, old + 32'd1); else n_pass++;
    n_total++;
    if (y_q !== old) $display("FAIL rdl_y: got %h want %h", y_q, old); else n_pass++;
    n_total++;
    $display("read-during-load: old=%h zlow=%h y=%h", old, zlow_q, y_q);
  endtask

  task automatic test_async_reset();
    load_y(32'hA5A5_0001);
    run_op(5'b01111, 32'h0001_0003);
    @(negedge clock);
    idle(); Zlowout = 1'b1; Yin = 1'b1; Zlowin = 1'b1; opcode = 5'b10010;
    #2 clear = 1'b0;
    #1;
    if ({y_q, zhigh_q, zlow_q} !== 96'h0) $display("FAIL async_reset: got %h %h %h want 0", y_q, zhigh_q, zlow_q); else n_pass++;
    n_total++;
    if (BusMuxOut !== 32'h0) $display("FAIL async_reset_bus: got %h want 0", BusMuxOut); else n_pass++;
    n_total++;
    @(posedge clock); #1;
    if (zlow_q !== 32'h0) $display("FAIL reset_hold_zlow: got %h want 0", zlow_q); else n_pass++;
    n_total++;
    @(negedge clock);
    clear = 1'b1; idle();
    y_m = 0; zh_m = 0; zl_m = 0;
    $display("async reset mid-cycle: y=%h zhigh=%h zlow=%h", y_q, zhigh_q, zlow_q);
  endtask

  task automatic test_random();
    logic [23:0] strobes;
    logic [31:0] exp_bus, h, l;
    logic        ey, eh, el, inc;
    logic [4:0]  op;
    for (int it = 0; it < 120; it++) begin
      @(negedge clock);
      for (int n = 0; n < 16; n++) set_r(n, $urandom);
      hi_q = $urandom; lo_q = $urandom; pc_q = $urandom; mdr_q = $urandom;
      inport_q = $urandom; c_sign_extended = $urandom;
      case ($urandom_range(4))
        0: strobes = 24'h0;
        1: strobes = 24'h1 << $urandom_range(23);
        2: strobes = (24'h1 << $urandom_range(19, 18)) | (24'(($urandom & 32'hF)) << 20);
        default: strobes = 24'($urandom) & 24'($urandom);
      endcase
      r_out = strobes[15:0]; HIout = strobes[16]; LOout = strobes[17];
      Zhighout = strobes[18]; Zlowout = strobes[19]; PCout = strobes[20];
      MDRout = strobes[21]; InPortout = strobes[22]; Cout = strobes[23];
      op = 5'($urandom_range(31));
      if ($urandom_range(3) == 0) op = 5'($urandom_range(18, 15));
      inc = ($urandom_range(7) == 0);
      ey = 1'($urandom); eh = 1'($urandom); el = 1'($urandom);
      opcode = op; IncPC = inc; Yin = ey; Zhighin = eh; Zlowin = el;
      #1;
      exp_bus = ref_bus(strobes);
      if (BusMuxOut !== exp_bus) $display("FAIL rnd_bus[%0d]: got %h want %h", it, BusMuxOut, exp_bus); else n_pass++;
      n_total++;
      ref_alu(op, y_m, exp_bus, inc, h, l);
      @(posedge clock); #1;
      if (ey) y_m = exp_bus;
      if (eh) zh_m = h;
      if (el) zl_m = l;
      if (y_q !== y_m) $display("FAIL rnd_y[%0d]: got %h want %h", it, y_q, y_m); else n_pass++;
      n_total++;
      if (zhigh_q !== zh_m) $display("FAIL rnd_zhigh[%0d]: got %h want %h", it, zhigh_q, zh_m); else n_pass++;
      n_total++;
      if (zlow_q !== zl_m) $display("FAIL rnd_zlow[%0d]: got %h want %h", it, zlow_q, zl_m); else n_pass++;
      n_total++;
      $display("rnd %0d: strobes=%h op=%b inc=%b bus=%h y=%h zhigh=%h zlow=%h",
               it, strobes, op, inc, BusMuxOut, y_q, zhigh_q, zlow_q);
    end
    @(negedge clock);
    idle();
  endtask

  initial begin
    r_q = '0; hi_q = 0; lo_q = 0; pc_q = 0; mdr_q = 0; inport_q = 0;
    c_sign_extended = 0;
    y_m = 0; zh_m = 0; zl_m = 0;
    idle();
    test_reset();
    test_mux();
    test_add_sub();
    test_mul_div();
    test_shifts();
    test_read_during_load();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
